// File: rtl/mosi_spi_fifo_tx.sv
// FIFO-fed MOSI SPI transmitter with CS/DC framing for the SSD1331 OLED link.
// Define MOSI_SPI_LSB_FIRST_EN to serialise bit 0 first; default is MSB first.
module mosi_spi_fifo_tx #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int CS_GAP = 0
) (
    input  logic                   i_SCK,
    input  logic                   i_RST,
    input  logic [WIDTH-1:0]       i_DATA,
    input  logic                   i_DC,
    input  logic                   i_WR,
    output logic                   o_FULL,
    output logic                   o_EMPTY,
    output logic [$clog2(DEPTH):0] o_LEVEL,
    output logic                   o_OVERFLOW,
    output logic                   o_MOSI,
    output logic                   o_CS,
    output logic                   o_DC,
    output logic                   o_BUSY,
    output logic                   o_MOSI_FINAL_TX
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LOAD = (CS_GAP > 0) ? 4'(CS_GAP - 1) : 4'd0;
    localparam bit            STREAM   = (CS_GAP == 0);

`ifdef MOSI_SPI_LSB_FIRST_EN
    localparam int FIRST_BIT = 0;
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return v >> 1;
    endfunction
`else
    localparam int FIRST_BIT = WIDTH - 1;
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return v << 1;
    endfunction
`endif

    typedef struct packed {
        logic             dc;
        logic [WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic            push, pop;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gap_q, gap_d;
    logic            cs_q, cs_d, mosi_q, mosi_d, dc_q, dc_d;

    assign push = i_WR && !full_q;
    assign head = mem[rd_ptr_q];

    // NOTE: storage is deliberately not reset; reset only clears pointers and level,
    // and an entry is never read before it has been written.
    always_ff @(posedge i_SCK) begin
        if (push) begin
            mem[wr_ptr_q] <= '{dc: i_DC, data: i_DATA};
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q || (i_WR && full_q);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: pop = !empty_q;
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CW'(1);
                    mosi_d  = shreg_q[FIRST_BIT];
                    shreg_d = advance(shreg_q);
                end else if (STREAM && !empty_q) begin
                    pop = 1'b1;
                end else begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
                    if (STREAM) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                // The last gap cycle doubles as the idle decision so CS stays high exactly CS_GAP cycles.
                if (gap_q != '0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!empty_q) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d = SHIFT;
            cnt_d   = CNT_MAX;
            cs_d    = 1'b0;
            dc_d    = head.dc;
            mosi_d  = head.data[FIRST_BIT];
            shreg_d = advance(head.data);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            dc_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            dc_q       <= dc_d;
        end
    end

    assign o_FULL          = full_q;
    assign o_EMPTY         = empty_q;
    assign o_LEVEL         = level_q;
    assign o_OVERFLOW      = overflow_q;
    assign o_MOSI          = mosi_q;
    assign o_CS            = cs_q;
    assign o_DC            = dc_q;
    assign o_BUSY          = (state_q != IDLE);
    assign o_MOSI_FINAL_TX = (state_q == SHIFT) && (cnt_q == '0);

endmodule

// File: tb/tb_mosi_spi_fifo_tx.sv
// Scoreboard bench: two instances (streaming and CS_GAP=3) share stimulus and are
// checked against a word-timing model and an expected-word queue per instance.
module tb_mosi_spi_fifo_tx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int GAP1  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr  = 1'b0;
    logic dc  = 1'b0;
    logic [WIDTH-1:0] data = '0;

    logic          full [2];
    logic          empty[2];
    logic [LW-1:0] level[2];
    logic          ovf_o[2];
    logic          mosi [2];
    logic          cs   [2];
    logic          dc_o [2];
    logic          busy [2];
    logic          fin  [2];

    always #5 clk = ~clk;

    mosi_spi_fifo_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CS_GAP(0)) u_dut0 (
        .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_DC(dc), .i_WR(wr),
        .o_FULL(full[0]), .o_EMPTY(empty[0]), .o_LEVEL(level[0]), .o_OVERFLOW(ovf_o[0]),
        .o_MOSI(mosi[0]), .o_CS(cs[0]), .o_DC(dc_o[0]), .o_BUSY(busy[0]),
        .o_MOSI_FINAL_TX(fin[0])
    );

    mosi_spi_fifo_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CS_GAP(GAP1)) u_dut1 (
        .i_SCK(clk), .i_RST(rst), .i_DATA(data), .i_DC(dc), .i_WR(wr),
        .o_FULL(full[1]), .o_EMPTY(empty[1]), .o_LEVEL(level[1]), .o_OVERFLOW(ovf_o[1]),
        .o_MOSI(mosi[1]), .o_CS(cs[1]), .o_DC(dc_o[1]), .o_BUSY(busy[1]),
        .o_MOSI_FINAL_TX(fin[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO occupancy as a count, and a transmitter that may start a
    // new word no earlier than WIDTH+gap edges after the previous start.
    int           m_lvl[2];
    bit           m_ovf[2];
    longint       last_pop[2];
    longint       next_start[2];
    longint       cyc = 0;
    bit           started = 0;
    bit           accept, popw;
    logic [WIDTH:0] q0[$];
    logic [WIDTH:0] q1[$];
    logic [WIDTH-1:0] acc[2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : GAP1;
    endfunction

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic d, input logic [WIDTH-1:0] v);
        rst  = r;
        wr   = w;
        dc   = d;
        data = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    // Model process: advances on each active edge using the inputs the DUTs sampled.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 0; m_ovf[k] = 0; last_pop[k] = -1000; next_start[k] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_lvl[k] = 0;
                    m_ovf[k] = 0;
                    last_pop[k] = -1000;
                    next_start[k] = 0;
                    if (k == 0) q0.delete(); else q1.delete();
                end else begin
                    accept = wr && (m_lvl[k] < DEPTH);
                    popw   = (m_lvl[k] > 0) && (cyc >= next_start[k]);
                    if (wr && !accept) m_ovf[k] = 1'b1;
                    if (accept) begin
                        if (k == 0) q0.push_back({dc, data}); else q1.push_back({dc, data});
                    end
                    if (popw) begin
                        last_pop[k]   = cyc;
                        next_start[k] = cyc + WIDTH + gap_of(k);
                    end
                    m_lvl[k] = m_lvl[k] + int'(accept) - int'(popw);
                end
            end
            if (rst) started = 1'b1;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard when a word completes.
    initial begin
        bit          cs_low, exp_busy;
        longint      idx;
        logic [WIDTH:0] exp_word;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < 2; k++) begin
                    cs_low   = (cyc < last_pop[k] + WIDTH);
                    exp_busy = (cyc < last_pop[k] + WIDTH + gap_of(k));
                    idx      = cyc - last_pop[k];
                    check("level", k, 64'(level[k]), 64'(m_lvl[k]));
                    check("full", k, 64'(full[k]), 64'(m_lvl[k] == DEPTH));
                    check("empty", k, 64'(empty[k]), 64'(m_lvl[k] == 0));
                    check("overflow", k, 64'(ovf_o[k]), 64'(m_ovf[k]));
                    check("cs", k, 64'(cs[k]), 64'(!cs_low));
                    check("busy", k, 64'(busy[k]), 64'(exp_busy));
                    check("final", k, 64'(fin[k]), 64'(cs_low && idx == WIDTH - 1));
                    if (!cs_low) begin
                        check("mosi_idle", k, 64'(mosi[k]), 64'd0);
                    end else begin
                        if (idx == 0) acc[k] = '0;
`ifdef MOSI_SPI_LSB_FIRST_EN
                        acc[k][idx] = mosi[k];
`else
                        acc[k][WIDTH - 1 - idx] = mosi[k];
`endif
                    end
                    if (fin[k] === 1'b1) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            check("sb_underflow", k, 64'd1, 64'd0);
                        end else begin
                            exp_word = (k == 0) ? q0.pop_front() : q1.pop_front();
                            check("word", k, 64'({dc_o[k], acc[k]}), 64'(exp_word));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int p;
        // Reset for two edges, then a single data word.
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 8'hA5);
        idle(30);
        // Four back-to-back words with mixed D/C.
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hC2);
        idle(60);
        // Seven consecutive writes into a four-deep FIFO.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'($urandom), 8'($urandom));
        idle(90);
        // Abort a word after its third bit, then send a clean word.
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        idle(3);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 8'h81);
        idle(30);
        // Random traffic with varying write density and occasional resets.
        for (int b = 0; b < 10; b++) begin
            p = $urandom_range(15, 95);
            for (int i = 0; i < 80; i++) begin
                step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < p),
                     1'($urandom), 8'($urandom));
            end
        end
        idle(120);
        check("sb_drain", 0, 64'(q0.size()), 64'd0);
        check("sb_drain", 1, 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
